// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the quad-SPI bus arbiter: FSM encoding, requester
// indices and the values driven onto the pads when nobody owns the bus.
package qspi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GUARD = 2'd2
   } arb_state_e;

   localparam logic REQ_FLASH = 1'b0;
   localparam logic REQ_ML    = 1'b1;

   // Safe pad state: chip selects deasserted, clocks parked low, IO released.
   localparam logic       PAD_CSB_SAFE = 1'b1;
   localparam logic       PAD_CLK_SAFE = 1'b0;
   localparam logic [3:0] PAD_IO_SAFE  = 4'h0;
   localparam logic [3:0] PAD_OE_SAFE  = 4'h0;

   // One-hot grant vector for a requester index.
   function automatic logic [1:0] owner_onehot(input logic idx);
      return (idx == REQ_ML) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/qspi_pad_mux.sv
// Owner-to-pad steering. Only the current owner reaches the pads; the other
// pad and every pad outside a grant sit in the safe state.
module qspi_pad_mux
   import qspi_arb_pkg::*;
(
   input  logic       grant_i,
   input  logic       owner_i,
   input  logic [1:0] m_clk_i,
   input  logic [1:0] m_csb_i,
   input  logic [7:0] m_io_out_i,
   input  logic [7:0] m_io_oe_i,
   output logic       flash_clk_o,
   output logic       flash_csb_o,
   output logic       ml_clk_o,
   output logic       ml_csb_o,
   output logic [3:0] io_out_o,
   output logic [3:0] io_oe_o
);

   // Safe defaults first, then pass the owner's signals through during a grant.
   always_comb begin
      flash_clk_o = PAD_CLK_SAFE;
      flash_csb_o = PAD_CSB_SAFE;
      ml_clk_o    = PAD_CLK_SAFE;
      ml_csb_o    = PAD_CSB_SAFE;
      io_out_o    = PAD_IO_SAFE;
      io_oe_o     = PAD_OE_SAFE;
      if (grant_i) begin
         if (owner_i == REQ_FLASH) begin
            flash_clk_o = m_clk_i[0];
            flash_csb_o = m_csb_i[0];
            io_out_o    = m_io_out_i[3:0];
            io_oe_o     = m_io_oe_i[3:0];
         end else begin
            ml_clk_o    = m_clk_i[1];
            ml_csb_o    = m_csb_i[1];
            io_out_o    = m_io_out_i[7:4];
            io_oe_o     = m_io_oe_i[7:4];
         end
      end
   end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-requester arbiter for the shared quad-SPI IO bus (flash controller and
// accelerator host port) with guard gaps and a hold-time watchdog.
//
// Handshake: req_i[n] is a level request; gnt_o[n] rises one cycle after an
// unmasked request is seen in IDLE and stays high until req_i[n] is sampled
// low (or the watchdog fires). Dropping req_i releases the bus on the next
// edge; the requester must not drive the bus once gnt_o[n] is low.
module qspi_bus_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES = 2,
   parameter int unsigned MAX_HOLD     = 4096,
   parameter int unsigned HOLD_W       = 13
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o,
   input  logic [1:0] m_clk_i,
   input  logic [1:0] m_csb_i,
   input  logic [7:0] m_io_out_i,
   input  logic [7:0] m_io_oe_i,
   input  logic [3:0] io_in_i,
   output logic [7:0] m_io_in_o,
   output logic       flash_clk_o,
   output logic       flash_csb_o,
   output logic       ml_clk_o,
   output logic       ml_csb_o,
   output logic [3:0] io_out_o,
   output logic [3:0] io_oe_o,
   output logic       busy_o,
   output logic       timeout_err_o,
   output logic       proto_err_o,
   output arb_state_e state_o
);

   localparam logic              WDOG_EN    = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
   localparam logic [3:0]        GUARD_LAST = 4'(GUARD_CYCLES - 1);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              rr_q, rr_d;
   logic [1:0]        mask_q, mask_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        guard_q, guard_d;
   logic              terr_q, terr_d;
   logic              perr_q, perr_d;
   logic [1:0]        elig;
   logic              winner;

   // Next-state logic: owner selection, release/watchdog exit, guard countdown.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      mask_d  = mask_q & req_i;        // a low request clears its mask bit
      hold_d  = hold_q;
      guard_d = guard_q;
      terr_d  = 1'b0;
      perr_d  = 1'b0;
      elig    = req_i & ~mask_q;
      // Contention goes to the round-robin pointer; otherwise the lone requester.
      winner  = (elig == 2'b11) ? rr_q : elig[1];
      case (state_q)
         ST_IDLE: begin
            if (|elig) begin
               state_d = ST_GRANT;
               owner_d = winner;
               rr_d    = ~winner;      // the loser is preferred next time
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            hold_d = hold_q + HOLD_W'(1);
            if (!req_i[owner_q]) begin
               state_d = ST_GUARD;
               guard_d = '0;
               perr_d  = ~m_csb_i[owner_q];
            end else if (WDOG_EN && (hold_q == HOLD_LAST)) begin
               state_d         = ST_GUARD;
               guard_d         = '0;
               terr_d          = 1'b1;
               mask_d[owner_q] = 1'b1;
            end
         end
         ST_GUARD: begin
            if (guard_q == GUARD_LAST) begin
               state_d = ST_IDLE;
            end else begin
               guard_d = guard_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters, pointer, mask and error pulses.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         owner_q <= REQ_FLASH;
         rr_q    <= REQ_FLASH;
         mask_q  <= 2'b00;
         hold_q  <= '0;
         guard_q <= '0;
         terr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         mask_q  <= mask_d;
         hold_q  <= hold_d;
         guard_q <= guard_d;
         terr_q  <= terr_d;
         perr_q  <= perr_d;
      end
   end

   assign gnt_o         = (state_q == ST_GRANT) ? owner_onehot(owner_q) : 2'b00;
   assign busy_o        = (state_q != ST_IDLE);
   assign timeout_err_o = terr_q;
   assign proto_err_o   = perr_q;
   assign state_o       = state_q;
   assign m_io_in_o     = {io_in_i, io_in_i};

   qspi_pad_mux u_pad_mux (
      .grant_i     (state_q == ST_GRANT),
      .owner_i     (owner_q),
      .m_clk_i     (m_clk_i),
      .m_csb_i     (m_csb_i),
      .m_io_out_i  (m_io_out_i),
      .m_io_oe_i   (m_io_oe_i),
      .flash_clk_o (flash_clk_o),
      .flash_csb_o (flash_csb_o),
      .ml_clk_o    (ml_clk_o),
      .ml_csb_o    (ml_csb_o),
      .io_out_o    (io_out_o),
      .io_oe_o     (io_oe_o)
   );

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: directed scenarios, a per-cycle reference model
// of the arbitration rules, and bus-level invariant checks.
module tb_qspi_bus_arbiter;
   import qspi_arb_pkg::*;

   localparam int G  = 2;
   localparam int MH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req;
   logic [1:0] m_clk;
   logic [1:0] m_csb;
   logic [7:0] m_io_out;
   logic [7:0] m_io_oe;
   logic [3:0] io_in;
   logic [1:0] gnt_o;
   logic [7:0] m_io_in_o;
   logic       flash_clk_o, flash_csb_o, ml_clk_o, ml_csb_o;
   logic [3:0] io_out_o, io_oe_o;
   logic       busy_o, timeout_err_o, proto_err_o;
   arb_state_e state_o;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- clock / DUT ----------------
   always #5 clk = ~clk;

   qspi_bus_arbiter #(.GUARD_CYCLES(G), .MAX_HOLD(MH), .HOLD_W(13)) dut (
      .clk_i(clk), .reset_i(reset), .req_i(req), .gnt_o(gnt_o),
      .m_clk_i(m_clk), .m_csb_i(m_csb), .m_io_out_i(m_io_out), .m_io_oe_i(m_io_oe),
      .io_in_i(io_in), .m_io_in_o(m_io_in_o),
      .flash_clk_o(flash_clk_o), .flash_csb_o(flash_csb_o),
      .ml_clk_o(ml_clk_o), .ml_csb_o(ml_csb_o),
      .io_out_o(io_out_o), .io_oe_o(io_oe_o), .busy_o(busy_o),
      .timeout_err_o(timeout_err_o), .proto_err_o(proto_err_o), .state_o(state_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Wait n rising edges, leaving time 1 unit past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- reference model ----------------
   // m_owner: -1 when nobody owns the bus; m_cool: guard cycles still to go;
   // m_held: cycles the current grant has lasted, including the present one.
   int         m_owner = -1, m_cool = 0, m_held = 0, m_rr = 0;
   bit   [1:0] m_mask = 2'b00;
   bit         m_terr = 1'b0, m_perr = 1'b0;
   // invariant tracking
   int         gap_run = 0;
   bit         had_grant = 1'b0;
   logic [1:0] prev_gnt = 2'b00;
   int         wait_cnt [2] = '{0, 0};

   always @(posedge clk) begin
      bit [1:0] nmask, elig;
      int pick;
      logic [1:0] e_gnt;
      logic e_fclk, e_fcsb, e_mclk, e_mcsb, e_busy;
      logic [3:0] e_io, e_oe;
      // advance the model with the inputs presented at this edge
      if (reset) begin
         m_owner = -1; m_cool = 0; m_held = 0; m_rr = 0; m_mask = 2'b00;
         m_terr = 1'b0; m_perr = 1'b0;
         had_grant = 1'b0; gap_run = 0; wait_cnt[0] = 0; wait_cnt[1] = 0;
      end else begin
         nmask = m_mask & req;
         m_terr = 1'b0;
         m_perr = 1'b0;
         if (m_owner >= 0) begin
            if (!req[m_owner]) begin
               m_perr = !m_csb[m_owner];
               m_owner = -1;
               m_cool = G;
            end else if (m_held == MH) begin
               m_terr = 1'b1;
               nmask[m_owner] = 1'b1;
               m_owner = -1;
               m_cool = G;
            end else begin
               m_held++;
            end
         end else if (m_cool > 0) begin
            m_cool--;
         end else begin
            elig = req & ~m_mask;
            if (elig == 2'b11) pick = m_rr;
            else if (elig == 2'b01) pick = 0;
            else if (elig == 2'b10) pick = 1;
            else pick = -1;
            if (pick >= 0) begin
               m_owner = pick;
               m_held = 1;
               m_rr = 1 - pick;
            end
         end
         m_mask = nmask;
      end
      #1;
      // expected outputs from the model
      e_gnt = 2'b00; e_fclk = 1'b0; e_fcsb = 1'b1; e_mclk = 1'b0; e_mcsb = 1'b1;
      e_io = 4'h0; e_oe = 4'h0;
      if (m_owner == 0) begin
         e_gnt = 2'b01; e_fclk = m_clk[0]; e_fcsb = m_csb[0];
         e_io = m_io_out[3:0]; e_oe = m_io_oe[3:0];
      end else if (m_owner == 1) begin
         e_gnt = 2'b10; e_mclk = m_clk[1]; e_mcsb = m_csb[1];
         e_io = m_io_out[7:4]; e_oe = m_io_oe[7:4];
      end
      e_busy = (m_owner >= 0) || (m_cool > 0);
      chk("gnt", gnt_o, e_gnt);
      chk("flash_clk", flash_clk_o, e_fclk);
      chk("flash_csb", flash_csb_o, e_fcsb);
      chk("ml_clk", ml_clk_o, e_mclk);
      chk("ml_csb", ml_csb_o, e_mcsb);
      chk("io_out", io_out_o, e_io);
      chk("io_oe", io_oe_o, e_oe);
      chk("busy", busy_o, e_busy);
      chk("timeout_err", timeout_err_o, m_terr);
      chk("proto_err", proto_err_o, m_perr);
      chk("m_io_in", m_io_in_o, {io_in, io_in});
      // bus invariants on the DUT outputs
      chk("gnt_not_both", (gnt_o == 2'b11), 1'b0);
      chk("csb_overlap", (!flash_csb_o && !ml_csb_o), 1'b0);
      if (gnt_o == 2'b00) begin
         gap_run++;
      end else begin
         if (prev_gnt == 2'b00 && had_grant) chk("guard_gap_ge3", (gap_run >= G + 1), 1'b1);
         gap_run = 0;
         had_grant = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         if (!req[i] || gnt_o[i]) wait_cnt[i] = 0;
         else if (prev_gnt == 2'b00 && gnt_o[1-i] && !m_mask[i]) begin
            wait_cnt[i]++;
            chk("wait_le_one_grant", (wait_cnt[i] <= 1), 1'b1);
         end
      end
      prev_gnt = gnt_o;
   end

   // ---------------- directed + random stimulus ----------------
   int held_t [2];
   int lim    [2];

   initial begin
      reset = 1'b1; req = 2'b00; m_clk = 2'b00; m_csb = 2'b11;
      m_io_out = 8'h00; m_io_oe = 8'h00; io_in = 4'h9;
      tick(2);
      chk("rst_gnt", gnt_o, 2'b00);
      chk("rst_flash_csb", flash_csb_o, 1'b1);
      chk("rst_ml_csb", ml_csb_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_io_oe", io_oe_o, 4'h0);
      chk("rst_state", state_o, ST_IDLE);

      // single flash request, pads follow flash
      @(negedge clk);
      reset = 1'b0; req = 2'b01; m_csb = 2'b10; m_clk = 2'b01;
      m_io_out = 8'h3C; m_io_oe = 8'hA5;
      tick(1);
      chk("t1_gnt", gnt_o, 2'b01);
      chk("t1_flash_csb", flash_csb_o, 1'b0);
      chk("t1_ml_csb", ml_csb_o, 1'b1);
      chk("t1_flash_clk", flash_clk_o, 1'b1);
      chk("t1_io_oe", io_oe_o, 4'h5);
      chk("t1_io_out", io_out_o, 4'hC);
      @(negedge clk);
      req = 2'b00; m_csb = 2'b11;
      tick(1);
      chk("t1_guard_gnt", gnt_o, 2'b00);
      chk("t1_guard_busy", busy_o, 1'b1);
      chk("t1_guard_oe", io_oe_o, 4'h0);
      tick(3);
      chk("t1_idle_busy", busy_o, 1'b0);

      // simultaneous requests out of reset, round robin
      @(negedge clk);
      reset = 1'b1;
      tick(1);
      @(negedge clk);
      reset = 1'b0; req = 2'b11;
      tick(1);
      chk("t2_first", gnt_o, 2'b01);
      tick(1);
      @(negedge clk);
      req = 2'b10;
      tick(1);
      chk("t2_guard_gnt", gnt_o, 2'b00);
      chk("t2_guard_oe", io_oe_o, 4'h0);
      tick(2);
      chk("t2_idle_gnt", gnt_o, 2'b00);
      tick(1);
      chk("t2_ml_4th", gnt_o, 2'b10);
      @(negedge clk);
      req = 2'b11;
      tick(1);
      @(negedge clk);
      req = 2'b01;
      tick(1);
      @(negedge clk);
      req = 2'b11;
      tick(3);
      chk("t2_flash_next", gnt_o, 2'b01);
      @(negedge clk);
      req = 2'b00;
      tick(4);

      // release while csb still low
      @(negedge clk);
      req = 2'b01; m_csb = 2'b10;
      tick(1);
      chk("t3_gnt", gnt_o, 2'b01);
      @(negedge clk);
      req = 2'b00;
      tick(1);
      chk("t3_proto", proto_err_o, 1'b1);
      chk("t3_csb_high", flash_csb_o, 1'b1);
      tick(1);
      chk("t3_proto_once", proto_err_o, 1'b0);
      @(negedge clk);
      m_csb = 2'b11;
      tick(3);

      // watchdog on a stuck ml requester
      @(negedge clk);
      req = 2'b10;
      tick(16);
      chk("t4_gnt16", gnt_o, 2'b10);
      tick(1);
      chk("t4_drop", gnt_o, 2'b00);
      chk("t4_timeout", timeout_err_o, 1'b1);
      tick(6);
      chk("t4_masked", gnt_o, 2'b00);
      chk("t4_timeout_once", timeout_err_o, 1'b0);
      @(negedge clk);
      req = 2'b00;
      tick(1);
      @(negedge clk);
      req = 2'b10;
      tick(1);
      chk("t4_regrant", gnt_o, 2'b10);
      @(negedge clk);
      req = 2'b00;
      tick(4);

      // reset in the middle of a grant
      @(negedge clk);
      req = 2'b01; m_csb = 2'b10; m_io_oe = 8'h0F;
      tick(1);
      chk("t5_oe", io_oe_o, 4'hF);
      @(negedge clk);
      reset = 1'b1;
      tick(1);
      chk("t5_gnt", gnt_o, 2'b00);
      chk("t5_oe_off", io_oe_o, 4'h0);
      chk("t5_fcsb", flash_csb_o, 1'b1);
      chk("t5_mcsb", ml_csb_o, 1'b1);
      chk("t5_busy", busy_o, 1'b0);
      @(negedge clk);
      reset = 1'b0; req = 2'b00; m_csb = 2'b11;
      tick(1);

      // random back-to-back traffic
      held_t[0] = 0; held_t[1] = 0; lim[0] = 1; lim[1] = 1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (gnt_o[i]) begin
               held_t[i]++;
               if (held_t[i] >= lim[i]) begin
                  req[i] = 1'b0;
                  m_csb[i] = 1'($urandom_range(0, 1));
               end else begin
                  m_csb[i] = 1'b0;
               end
            end else begin
               held_t[i] = 0;
               m_csb[i] = 1'b1;
               if (!req[i] && ($urandom_range(0, 1) == 1)) begin
                  req[i] = 1'b1;
                  lim[i] = $urandom_range(1, 5);
               end
            end
         end
         m_clk = 2'($urandom_range(0, 3));
         m_io_out = 8'($urandom);
         m_io_oe = 8'($urandom);
         io_in = 4'($urandom);
      end
      @(negedge clk);
      req = 2'b00; m_csb = 2'b11;
      tick(5);
      chk("end_idle", busy_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qspi_bus_arbiter.md
Name: qspi_bus_arbiter

Overview:
Shares the single quad-SPI IO bus (io0..io3) between two requesters: port 0, the ctrlsoc flash memory controller (drives flash_clk/flash_csb), and port 1, the ctrlsoc host interface to mlaccel_top (drives ml_clk/ml_csb). It grants exactly one owner at a time and inserts guard cycles between owners with all chip selects high and all IO drivers off. A hold-time watchdog reclaims the bus from a stuck owner. The block sits inside ctrlsoc between the two SPI masters and the IO pads.

Parameters:
GUARD_CYCLES, 2, idle cycles (csb high, oe off) between any release and the next grant; legal range 1..15.
MAX_HOLD, 4096, maximum consecutive granted cycles before a forced release; 0 disables the watchdog.
HOLD_W, 13, width of the hold counter; must hold MAX_HOLD.

Ports:
clk  in  1  controller clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
req  in  2  per-requester bus request; level-sensitive, bit 0 = flash, bit 1 = ml.
gnt  out  2  one-hot-or-zero grant.
m_clk  in  2  per-requester SPI clock.
m_csb  in  2  per-requester chip select, active low.
m_io_out  in  8  per-requester IO output data; [3:0] = flash, [7:4] = ml.
m_io_oe  in  8  per-requester IO output enables; same packing.
io_in  in  4  pad input data, broadcast to both requesters unregistered.
flash_clk  out  1  flash pad clock.
flash_csb  out  1  flash pad chip select.
ml_clk  out  1  accelerator pad clock.
ml_csb  out  1  accelerator pad chip select.
io_out  out  4  shared pad output data.
io_oe  out  4  shared pad output enables.
busy  out  1  high in GRANT or GUARD.
timeout_err  out  1  one-cycle pulse on a watchdog release.
proto_err  out  1  one-cycle pulse when a requester releases with its csb still low.

Behaviour:
- Reset values: gnt=0, flash_csb=1, ml_csb=1, flash_clk=0, ml_clk=0, io_out=0, io_oe=0, busy=0, both error pulses 0. State=IDLE, round-robin pointer=0 (flash preferred), mask=0.
- States are IDLE, GRANT, and GUARD. The owner register holds the 1-bit index of the granted requester.
- IDLE: if any unmasked req bit is set, go to GRANT next cycle and assert gnt[owner] registered. This gives 1-cycle request-to-grant latency.
- Owner selection: with a single request, that requester wins. With simultaneous requests, the requester named by the round-robin pointer wins, and the pointer flips to the other requester on every grant.
- GRANT: pad outputs for the owner follow m_* combinationally (flash_clk=m_clk[0], and so on). The non-owner pad has csb=1 and clk=0. io_out and io_oe are muxed from the owner.
- GRANT exit: a cycle with req[owner]=0 drops gnt in the next cycle and enters GUARD. If m_csb[owner]=0 on that cycle, proto_err pulses; the pad csb is forced high from GUARD onward regardless.
- Watchdog: the hold counter clears on grant and increments each GRANT cycle. When it reaches MAX_HOLD-1 (MAX_HOLD≠0), the arbiter drops gnt, pulses timeout_err, enters GUARD, and sets mask[owner].
- Masking: a masked requester is ignored until its req is sampled low, which clears its mask bit.
- GUARD: both csb=1, both clk=0, io_oe=0, io_out=0. The arbiter counts GUARD_CYCLES and then goes to IDLE. A pending request is granted on the IDLE cycle, so the minimum gap is GUARD_CYCLES+1 cycles.
- No preemption: a new request from the non-owner never shortens a grant.
- Reset asserted mid-GRANT or mid-GUARD returns to IDLE with reset values on the following edge. The pads are safe (csb high, oe off) from that edge.
- gnt never has both bits set. io_oe is nonzero only in GRANT.

Decomposition:
- Shared package qspi_arb_pkg holds:
  - the state encoding: ST_IDLE, ST_GRANT, ST_GUARD;
  - the requester index constants: REQ_FLASH=0, REQ_ML=1;
  - the pad-safe constants.
- One natural sub-module, qspi_pad_mux: the combinational owner-to-pad mux plus safe-state forcing. The FSM, counters, pointer and mask stay in qspi_bus_arbiter.

Test Plan:
1. Reset, then req=01 → gnt=01 one cycle later. flash_csb tracks m_csb[0]; ml_csb=1; io_oe=m_io_oe[3:0].
2. req=11 raised on the same cycle from reset → gnt=01. Drop req[0] → GUARD for 2 cycles with io_oe=0, then gnt=10 on cycle 4 after the drop. Repeat → flash wins next.
3. The owner drops req while m_csb=0 → proto_err pulses once, and the pad csb is high on the next cycle.
4. MAX_HOLD=16 with req[1] held high → gnt[1] falls after 16 grant cycles and timeout_err pulses once. No regrant while req[1] stays high; req[1] low for 1 cycle then high → regranted after the guard.
5. Assert reset during GRANT with io_oe=F → the next edge gives gnt=0, io_oe=0, both csb=1, busy=0.
6. Alternating back-to-back requests for 100 random cycles → a checker confirms gnt is never 11, there is never a csb-low overlap, the guard gap is ≥3 cycles, and no requester waits more than one other grant.
